// File: rtl/r5p_bus_arb.sv
// Two-port (instruction fetch + load/store) to one-port memory bus arbiter.
// Grant is locked from request until acknowledge; read data is returned and held per port.
module r5p_bus_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned BW         = DW/8,
  parameter int unsigned PRIO       = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch port (read only)
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdt,
  output logic          if_ack,
  // load/store port
  input  logic          ls_req,
  input  logic          ls_wen,
  input  logic [AW-1:0] ls_adr,
  input  logic [BW-1:0] ls_ben,
  input  logic [DW-1:0] ls_wdt,
  output logic [DW-1:0] ls_rdt,
  output logic          ls_ack,
  // shared memory port
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_adr,
  output logic [BW-1:0] mem_ben,
  output logic [DW-1:0] mem_wdt,
  input  logic [DW-1:0] mem_rdt,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_IF   = 2'd1,
    PORT_LS   = 2'd2
  } port_t;

  localparam int unsigned   SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  port_t         r_own;
  logic          r_lock;
  port_t         r_rsp;
  port_t         r_last;
  logic [SW-1:0] r_starve_cnt;
  logic [DW-1:0] r_if_hold;
  logic [DW-1:0] r_ls_hold;

  port_t         w_grant;
  logic          w_hs;

  // Grant never depends on mem_ack, so there is no ack-to-request loop.
  // Nothing is granted while reset is held, so requests cannot leak to memory.
  always_comb begin
    w_grant = PORT_NONE;
    if (!rst) begin
      w_grant = PORT_NONE;
    end else if (r_lock) begin
      w_grant = r_own;
    end else if (if_req && ls_req) begin
      if (PRIO == 1) begin
        w_grant = (r_last == PORT_IF) ? PORT_LS : PORT_IF;
      end else if ((STARVE_MAX != 0) && (r_starve_cnt == STARVE_LIM)) begin
        w_grant = PORT_IF;
      end else begin
        w_grant = PORT_LS;
      end
    end else if (ls_req) begin
      w_grant = PORT_LS;
    end else if (if_req) begin
      w_grant = PORT_IF;
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    mem_req = 1'b0;
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_ben = '0;
    mem_wdt = '0;
    unique case (w_grant)
      PORT_IF: begin
        mem_req = if_req;
        mem_adr = if_adr;
        mem_ben = '1;
      end
      PORT_LS: begin
        mem_req = ls_req;
        mem_wen = ls_wen;
        mem_adr = ls_adr;
        mem_ben = ls_ben;
        mem_wdt = ls_wdt;
      end
      default: ;
    endcase
  end

  assign w_hs   = mem_req & mem_ack;
  assign if_ack = mem_ack & (w_grant == PORT_IF);
  assign ls_ack = mem_ack & (w_grant == PORT_LS);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_own        <= PORT_NONE;
      r_lock       <= 1'b0;
      r_rsp        <= PORT_NONE;
      r_last       <= PORT_IF;
      r_starve_cnt <= '0;
    end else begin
      // Lock holds while the owner keeps requesting unacknowledged; a dropped request frees it.
      r_lock <= mem_req & ~mem_ack;
      r_own  <= (mem_req && !mem_ack) ? w_grant : PORT_NONE;
      r_rsp  <= (w_hs && !mem_wen) ? w_grant : PORT_NONE;
      if (w_hs) begin
        r_last <= w_grant;
      end
      if (w_hs && (w_grant == PORT_IF)) begin
        r_starve_cnt <= '0;
      end else if (if_req && (w_grant != PORT_IF) && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // NOTE: hold registers are reset so read data is defined (zero) before the first read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_hold <= '0;
      r_ls_hold <= '0;
    end else begin
      if (r_rsp == PORT_IF) r_if_hold <= mem_rdt;
      if (r_rsp == PORT_LS) r_ls_hold <= mem_rdt;
    end
  end

  assign if_rdt = (r_rsp == PORT_IF) ? mem_rdt : r_if_hold;
  assign ls_rdt = (r_rsp == PORT_LS) ? mem_rdt : r_ls_hold;

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Directed bench for r5p_bus_arb: instance a uses fixed priority with anti-starvation,
// instance b uses round robin; both see the same stimulus.
module tb_r5p_bus_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_adr;
  logic          ls_req;
  logic          ls_wen;
  logic [AW-1:0] ls_adr;
  logic [BW-1:0] ls_ben;
  logic [DW-1:0] ls_wdt;
  logic [DW-1:0] mem_rdt;
  logic          mem_ack;

  logic [DW-1:0] a_if_rdt, a_ls_rdt, a_mem_wdt;
  logic          a_if_ack, a_ls_ack, a_mem_req, a_mem_wen;
  logic [AW-1:0] a_mem_adr;
  logic [BW-1:0] a_mem_ben;

  logic [DW-1:0] b_if_rdt, b_ls_rdt, b_mem_wdt;
  logic          b_if_ack, b_ls_ack, b_mem_req, b_mem_wen;
  logic [AW-1:0] b_mem_adr;
  logic [BW-1:0] b_mem_ben;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .PRIO(0), .STARVE_MAX(4)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdt(a_if_rdt), .if_ack(a_if_ack),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben), .ls_wdt(ls_wdt),
    .ls_rdt(a_ls_rdt), .ls_ack(a_ls_ack),
    .mem_req(a_mem_req), .mem_wen(a_mem_wen), .mem_adr(a_mem_adr), .mem_ben(a_mem_ben),
    .mem_wdt(a_mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
  );

  r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .PRIO(1), .STARVE_MAX(4)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdt(b_if_rdt), .if_ack(b_if_ack),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben), .ls_wdt(ls_wdt),
    .ls_rdt(b_ls_rdt), .ls_ack(b_ls_ack),
    .mem_req(b_mem_req), .mem_wen(b_mem_wen), .mem_adr(b_mem_adr), .mem_ben(b_mem_ben),
    .mem_wdt(b_mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Comparisons happen on the falling edge; inputs change just after the rising edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    if_req  = 1'b0;
    if_adr  = '0;
    ls_req  = 1'b0;
    ls_wen  = 1'b0;
    ls_adr  = '0;
    ls_ben  = '0;
    ls_wdt  = 32'hCAFE_F00D;
    mem_rdt = '0;
    mem_ack = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_ack",  a_if_ack,  0);
    check("rst_ls_ack",  a_ls_ack,  0);
    check("rst_if_rdt",  a_if_rdt,  0);
    check("rst_ls_rdt",  a_ls_rdt,  0);
    check("rst_mem_req", a_mem_req, 0);
    check("rst_b_mem_req", b_mem_req, 0);
    @(negedge clk);
    rst = 1'b1;
    next();

    // single IF reads, ack tied high
    mem_ack = 1'b1;
    if_req  = 1'b1;
    if_adr  = 32'h0;
    sample();
    check("if0_mem_req", a_mem_req, 1);
    check("if0_mem_adr", a_mem_adr, 32'h0);
    check("if0_if_ack",  a_if_ack,  1);
    check("if0_mem_wen", a_mem_wen, 0);
    check("if0_mem_ben", a_mem_ben, 32'hF);
    check("if0_mem_wdt", a_mem_wdt, 32'h0);
    next();
    if_adr  = 32'h4;
    mem_rdt = 32'h1111_0000;
    sample();
    check("if4_mem_adr", a_mem_adr, 32'h4);
    check("if4_if_ack",  a_if_ack,  1);
    check("if0_rdt",     a_if_rdt,  32'h1111_0000);
    next();
    if_adr  = 32'h8;
    mem_rdt = 32'h1111_0004;
    sample();
    check("if4_rdt", a_if_rdt, 32'h1111_0004);
    next();
    if_req  = 1'b0;
    mem_rdt = 32'h1111_0008;
    sample();
    check("if8_rdt",      a_if_rdt,  32'h1111_0008);
    check("idle_mem_req", a_mem_req, 0);
    check("idle_if_ack",  a_if_ack,  0);
    next();
    mem_rdt = 32'hBAD0_BAD0;
    sample();
    check("if_rdt_hold", a_if_rdt, 32'h1111_0008);
    next();

    // simultaneous requests, LS wins first
    if_req = 1'b1;
    if_adr = 32'h40;
    ls_req = 1'b1;
    ls_adr = 32'h100;
    ls_ben = 4'hF;
    sample();
    check("both_mem_adr", a_mem_adr, 32'h100);
    check("both_ls_ack",  a_ls_ack,  1);
    check("both_if_ack",  a_if_ack,  0);
    next();
    ls_req  = 1'b0;
    mem_rdt = 32'h2222_0100;
    sample();
    check("if_after_ls_adr", a_mem_adr, 32'h40);
    check("if_after_ls_ack", a_if_ack,  1);
    check("ls100_rdt",       a_ls_rdt,  32'h2222_0100);
    check("if_rdt_kept",     a_if_rdt,  32'h1111_0008);
    next();
    if_req  = 1'b0;
    mem_rdt = 32'h3333_0040;
    sample();
    check("if40_rdt", a_if_rdt, 32'h3333_0040);
    next();

    // starvation: LS requests every cycle, IF forced on the 5th contending cycle
    if_req  = 1'b1;
    if_adr  = 32'h80;
    ls_req  = 1'b1;
    ls_adr  = 32'h200;
    mem_rdt = 32'h4444_4444;
    for (int i = 1; i <= 4; i++) begin
      sample();
      check($sformatf("starve_ls_ack_%0d", i), a_ls_ack, 1);
      check($sformatf("starve_if_ack_%0d", i), a_if_ack, 0);
      next();
    end
    sample();
    check("starve_if_forced", a_if_ack,  1);
    check("starve_if_adr",    a_mem_adr, 32'h80);
    check("starve_ls_rdt",    a_ls_rdt,  32'h4444_4444);
    next();
    mem_rdt = 32'h5555_0080;
    sample();
    check("starve_cleared_ls", a_ls_ack,  1);
    check("starve_ls_adr",     a_mem_adr, 32'h200);
    check("rsp_with_new_hs",   a_if_rdt,  32'h5555_0080);
    next();
    if_req  = 1'b0;
    ls_req  = 1'b0;
    mem_rdt = 32'h6666_0200;
    sample();
    check("ls200_rdt",     a_ls_rdt, 32'h6666_0200);
    check("if80_rdt_held", a_if_rdt, 32'h5555_0080);
    next();

    // IF locked while memory stalls and LS arrives
    mem_ack = 1'b0;
    if_req  = 1'b1;
    if_adr  = 32'hC0;
    sample();
    check("lock_c1_adr", a_mem_adr, 32'hC0);
    check("lock_c1_ack", a_if_ack,  0);
    next();
    ls_req = 1'b1;
    ls_adr = 32'h300;
    sample();
    check("lock_c2_adr",    a_mem_adr, 32'hC0);
    check("lock_c2_ls_ack", a_ls_ack,  0);
    next();
    sample();
    check("lock_c3_adr", a_mem_adr, 32'hC0);
    next();
    mem_ack = 1'b1;
    sample();
    check("lock_c4_adr",    a_mem_adr, 32'hC0);
    check("lock_c4_if_ack", a_if_ack,  1);
    check("lock_c4_ls_ack", a_ls_ack,  0);
    next();
    if_req  = 1'b0;
    mem_rdt = 32'h7777_00C0;
    sample();
    check("unlock_ls_adr", a_mem_adr, 32'h300);
    check("unlock_ls_ack", a_ls_ack,  1);
    check("ifC0_rdt",      a_if_rdt,  32'h7777_00C0);
    next();
    ls_req  = 1'b0;
    mem_rdt = 32'h8888_0300;
    sample();
    check("ls300_rdt", a_ls_rdt, 32'h8888_0300);
    next();

    // LS partial write produces no response
    ls_req = 1'b1;
    ls_wen = 1'b1;
    ls_adr = 32'h20;
    ls_ben = 4'h3;
    ls_wdt = 32'hDEAD_BEEF;
    sample();
    check("wr_mem_wen", a_mem_wen, 1);
    check("wr_mem_ben", a_mem_ben, 32'h3);
    check("wr_mem_wdt", a_mem_wdt, 32'hDEAD_BEEF);
    check("wr_mem_adr", a_mem_adr, 32'h20);
    check("wr_ls_ack",  a_ls_ack,  1);
    next();
    ls_req  = 1'b0;
    ls_wen  = 1'b0;
    mem_rdt = 32'hBADB_AD00;
    sample();
    check("wr_ls_rdt_unchanged", a_ls_rdt, 32'h8888_0300);
    next();

    // round robin from a clean reset (last = IF, so LS goes first)
    rst = 1'b0;
    sample();
    rst = 1'b1;
    next();
    if_req = 1'b1;
    if_adr = 32'h400;
    ls_req = 1'b1;
    ls_adr = 32'h500;
    ls_ben = 4'hF;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("rr_ls_ack_%0d", i), b_ls_ack, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_if_ack_%0d", i), b_if_ack, (i % 2 == 0) ? 0 : 1);
      check($sformatf("rr_mem_adr_%0d", i), b_mem_adr, (i % 2 == 0) ? 32'h500 : 32'h400);
      next();
    end
    mem_ack = 1'b0;
    sample();
    check("rr_wait_adr",    b_mem_adr, 32'h500);
    check("rr_wait_ls_ack", b_ls_ack,  0);
    next();
    sample();
    check("rr_wait2_adr", b_mem_adr, 32'h500);
    check("rr_wait2_req", b_mem_req, 1);
    mem_ack = 1'b1;
    rst     = 1'b0;
    #1;
    check("rr_rst_mem_req", b_mem_req, 0);
    check("rr_rst_if_ack",  b_if_ack,  0);
    check("rr_rst_ls_ack",  b_ls_ack,  0);
    check("rr_rst_ls_rdt",  b_ls_rdt,  0);
    check("rr_rst_a_req",   a_mem_req, 0);
    if_req  = 1'b0;
    ls_req  = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
